// File: rtl/hex_disp_scan.sv
// hex_disp_scan: 4-digit multiplexed common-anode 7-segment driver.
// Shows a 16-bit value as four hex digits, one digit lit per refresh slot.
// The value is snapshotted once per scan frame so a frame never tears.
// Optional macro LEAD_ZERO_BLANK_EN blanks digits above the most-significant
// non-zero nibble (digit 0 always shown).
module hex_disp_scan #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned DIGITS      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame_tick
);

  localparam logic [15:0] TC   = 16'(REFRESH_DIV - 1);
  localparam logic [1:0]  LAST = 2'(DIGITS - 1);

  logic [15:0] prescaler;
  logic [15:0] snapshot;
  logic [1:0]  index;
  logic        primed;

  logic        terminal;
  logic        load;
  logic        blank;
  logic [3:0]  nibble;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0:    hex_seg = 7'b1000000;
      4'h1:    hex_seg = 7'b1111001;
      4'h2:    hex_seg = 7'b0100100;
      4'h3:    hex_seg = 7'b0110000;
      4'h4:    hex_seg = 7'b0011001;
      4'h5:    hex_seg = 7'b0010010;
      4'h6:    hex_seg = 7'b0000010;
      4'h7:    hex_seg = 7'b1111000;
      4'h8:    hex_seg = 7'b0000000;
      4'h9:    hex_seg = 7'b0010000;
      4'hA:    hex_seg = 7'b0001000;
      4'hB:    hex_seg = 7'b0000011;
      4'hC:    hex_seg = 7'b1000110;
      4'hD:    hex_seg = 7'b0100001;
      4'hE:    hex_seg = 7'b0000110;
      default: hex_seg = 7'b0001110;
    endcase
  endfunction

  // Slot end, frame reload decision and the nibble of the digit being scanned.
  always_comb begin
    terminal = (prescaler == TC);
    // First enabled cycle after reset primes the snapshot; afterwards it
    // reloads only as the index wraps from the last digit back to digit 0.
    load     = !primed || (terminal && (index == LAST));
    nibble   = snapshot[{index, 2'b00} +: 4];
`ifdef LEAD_ZERO_BLANK_EN
    // A digit is a leading zero when it and every digit above it are zero.
    blank    = (index != 2'd0) && ((snapshot >> {index, 2'b00}) == 16'h0000);
`else
    blank    = 1'b0;
`endif
  end

  // Scan state and registered display outputs; en=0 blanks and freezes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= 4'b1111;
      seg        <= 7'b1111111;
      frame_tick <= 1'b0;
      prescaler  <= 16'h0000;
      index      <= 2'd0;
      snapshot   <= 16'h0000;
      primed     <= 1'b0;
    end else if (en) begin
      an         <= blank ? 4'b1111 : ~(4'b0001 << index);
      seg        <= blank ? 7'b1111111 : hex_seg(nibble);
      frame_tick <= load;
      if (load) begin
        snapshot <= value;
        primed   <= 1'b1;
      end
      if (terminal) begin
        prescaler <= 16'h0000;
        index     <= (index == LAST) ? 2'd0 : index + 2'd1;
      end else begin
        prescaler <= prescaler + 16'd1;
      end
    end else begin
      an         <= 4'b1111;
      seg        <= 7'b1111111;
      frame_tick <= 1'b0;
    end
  end

endmodule

// File: doc/hex_disp_scan.md
Name: hex_disp_scan

Overview:
Downstream consumer of the 16-bit up/down counter value. Drives a 4-digit multiplexed common-anode 7-segment display, showing the value as 4 hex digits. Time-multiplexes the digits with a prescaled refresh tick. Snapshots the value once per scan frame so digits never tear mid-frame.

Parameters:
REFRESH_DIV, 16'd50000, clk cycles each digit stays lit; legal range 1..65535
DIGITS, 4, number of digits; fixed at 4 (nibble count of 16-bit value)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
value  input  16  counter value to display; sampled only at frame start
en  input  1  display enable; 0 blanks outputs and freezes scanning
an  output  4  digit anodes, active-low; an[i] selects value nibble i
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
frame_tick  output  1  1-cycle pulse when a new snapshot is taken

Behaviour:
- Reset is asynchronous, active-high, on clk and rst; clk is the only clock.
- Reset values:
  - an=4'b1111, seg=7'b1111111, frame_tick=0.
  - prescaler=0, digit index=0, snapshot=16'h0000, primed=0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 while en=1. Holds its value while en=0.
  - Terminal count (prescaler==REFRESH_DIV-1) wraps it to 0 and advances the index: 0→1→2→3→0.
  - REFRESH_DIV=1: terminal count every cycle, so the index advances every enabled cycle.
- Snapshot:
  - Loaded with value on the first enabled cycle after reset (primed=0; primed then set to 1).
  - Also loaded on each terminal count with index==3, i.e. the index wrap to 0.
  - frame_tick=1 in the cycle after each load; otherwise 0.
  - Changes to value between loads are not displayed.
- Output decode:
  - Registered, 1-cycle latency. an/seg at cycle t+1 reflect the index and snapshot at cycle t.
  - an has exactly one bit low: bit index low.
  - seg = hex decode of snapshot[4*index+3 : 4*index].
- Encodings (active-low {g..a}): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- en=0:
  - Next cycle: an=1111, seg=1111111, frame_tick=0.
  - Prescaler, index, snapshot and primed hold their values.
  - On en returning to 1, scanning resumes at the held index and prescaler.
- Simultaneous events:
  - rst overrides everything.
  - Snapshot load and index wrap happen in the same cycle. Digit 0 of the new frame shows the new snapshot.
- Reset mid-scan: outputs go to reset values immediately (asynchronous). The first enabled cycle after release re-primes the snapshot.

Optional Feature:
- Macro: LEAD_ZERO_BLANK_EN.
- Defined:
  - Digits above the most-significant non-zero nibble of the snapshot are blanked: their an bit stays 1 and seg=1111111 during their slot.
  - Slot timing is unchanged.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- Undefined: all 4 digits always displayed, including leading zeros.

Test Plan:
1. Assert rst, toggle clk -> an=1111, seg=1111111, frame_tick=0. Check before and after the first clk edge (asynchronous).
2. REFRESH_DIV=4, en=1, value=16'h12AF -> per 4-cycle slot:
   - an=1110 with seg=0001110 (F);
   - then an=1101 with seg=0001000 (A);
   - then an=1011 with seg=0100100 (2);
   - then an=0111 with seg=1111001 (1).
   - frame_tick pulses every 16 cycles.
3. REFRESH_DIV=4, value changes 16'h12AF→16'h0000 during the index=1 slot -> remaining slots still show A, 2, 1. The next frame shows 1000000 on all 4 digits (LEAD_ZERO_BLANK_EN undefined).
4. en=0 for 7 cycles mid-slot of index 2 -> an=1111 from the next cycle. On en=1, index 2 resumes with its remaining prescaler count. frame_tick stays 0 while en=0.
5. rst pulse during the index=3 slot -> immediate reset outputs. After release: snapshot reloads on the first enabled cycle, frame_tick pulses once, scanning starts at index 0.
6. LEAD_ZERO_BLANK_EN defined, value=16'h0030 -> digits 3 and 2 have an bit high and seg=1111111; digit 1 seg=0110000; digit 0 seg=1000000. value=16'h0000 -> only digit 0 lit, showing 1000000.
